// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam int unsigned MEM_ARB_TIMEOUT_DEFAULT = 8;
  localparam logic [3:0]  FETCH_BE                = 4'hF;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant selection between fetch and data requesters.
// MEM_ARB_RR_EN: round-robin on ties; otherwise data port has fixed priority.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic i_if_req,
  input  logic i_mem_req,
  input  logic i_last_owner,
  output logic o_winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    o_winner = OWN_IF;
    if (i_if_req && i_mem_req) begin
      // tie goes to whoever did not get the previous grant
      o_winner = (i_last_owner == OWN_IF) ? OWN_MEM : OWN_IF;
    end else if (i_mem_req) begin
      o_winner = OWN_MEM;
    end
  end
`else
  logic w_unused_inputs;
  assign w_unused_inputs = i_if_req ^ i_last_owner;

  always_comb begin
    o_winner = i_mem_req ? OWN_MEM : OWN_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) SRAM arbiter with access timeout.
// Optional round-robin tie-break under MEM_ARB_RR_EN.
//
// state  | meaning
// IDLE   | waiting for a request while not stalled
// ACCESS | sram_req high, waiting for sram_ready or timeout
// RESP   | one-cycle ack to the owner with rdata/err
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MEM_ARB_TIMEOUT_DEFAULT
) (
  input  logic        soc_clk,
  input  logic        MEM_reset,
  input  logic        MEM_stall,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_be,
  input  logic        mem_we,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        sram_req,
  output logic [31:0] sram_addr,
  output logic [3:0]  sram_be,
  output logic        sram_we,
  output logic [31:0] sram_wdata,
  input  logic        sram_ready,
  input  logic [31:0] sram_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  owner_t      r_owner;
  logic [7:0]  r_tmo_cnt;
  logic [31:0] r_sram_addr;
  logic [31:0] r_sram_wdata;
  logic [3:0]  r_sram_be;
  logic        r_sram_we;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_grant;
  logic        w_done;
  logic        w_timeout;
  logic        w_winner;
  logic        w_last_owner;

`ifdef MEM_ARB_RR_EN
  // the owner record doubles as the round-robin pointer
  assign w_last_owner = r_owner;
`else
  assign w_last_owner = OWN_IF;
`endif

  mem_arb_picker u_picker (
    .i_if_req     (if_req),
    .i_mem_req    (mem_req),
    .i_last_owner (w_last_owner),
    .o_winner     (w_winner)
  );

  always_ff @(posedge soc_clk or posedge MEM_reset) begin
    if (MEM_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    sram_req    = 1'b0;
    if_ack      = 1'b0;
    mem_ack     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if ((if_req || mem_req) && !MEM_stall) begin
          w_grant     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        sram_req = 1'b1;
        // a ready on the final allowed cycle still counts as success
        if (sram_ready) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (r_tmo_cnt >= TMO_LAST) begin
          w_done      = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if_ack      = (r_owner == OWN_IF);
        mem_ack     = (r_owner == OWN_MEM);
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge soc_clk or posedge MEM_reset) begin
    if (MEM_reset) begin
      r_owner      <= OWN_IF;
      r_tmo_cnt    <= 8'd0;
      r_sram_addr  <= 32'd0;
      r_sram_wdata <= 32'd0;
      r_sram_be    <= 4'd0;
      r_sram_we    <= 1'b0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner   <= owner_t'(w_winner);
        r_tmo_cnt <= 8'd0;
        if (w_winner == OWN_MEM) begin
          r_sram_addr  <= mem_addr;
          r_sram_be    <= mem_be;
          r_sram_we    <= mem_we;
          r_sram_wdata <= mem_wdata;
        end else begin
          r_sram_addr  <= if_addr;
          r_sram_be    <= FETCH_BE;
          r_sram_we    <= 1'b0;
          r_sram_wdata <= 32'd0;
        end
      end else if (r_state == ACCESS && r_tmo_cnt != 8'hFF) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end

      if (w_done) begin
        r_rdata <= (w_timeout || r_sram_we) ? 32'd0 : sram_rdata;
        r_err   <= w_timeout;
      end
    end
  end

  assign sram_addr  = r_sram_addr;
  assign sram_be    = r_sram_be;
  assign sram_we    = r_sram_we;
  assign sram_wdata = r_sram_wdata;
  assign rdata      = r_rdata;
  assign err        = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized rounds against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TMO = 8;

  logic        soc_clk = 1'b0;
  logic        MEM_reset, MEM_stall;
  logic        if_req, mem_req, mem_we, sram_ready;
  logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
  logic [3:0]  mem_be;
  logic        if_ack, mem_ack, err, sram_req, sram_we;
  logic [31:0] rdata, sram_addr, sram_wdata;
  logic [3:0]  sram_be;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: outstanding requests, their payloads, last grant
  bit          if_pend, mem_pend;
  owner_t      m_last;
  logic [31:0] m_if_addr, m_mem_addr, m_mem_wdata;
  logic [3:0]  m_mem_be;
  logic        m_mem_we;

  // payload for the next newly raised request / SRAM read data
  logic [31:0] p_if_addr, p_mem_addr, p_mem_wdata, p_rdata;
  logic [3:0]  p_mem_be;
  logic        p_mem_we;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .soc_clk(soc_clk), .MEM_reset(MEM_reset), .MEM_stall(MEM_stall),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .rdata(rdata), .err(err),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_be(sram_be), .sram_we(sram_we),
    .sram_wdata(sram_wdata), .sram_ready(sram_ready), .sram_rdata(sram_rdata)
  );

  always #5 soc_clk = ~soc_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic do_reset();
    MEM_reset = 1'b1; MEM_stall = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_addr = '0; mem_be = '0; mem_we = 1'b0; mem_wdata = '0;
    sram_ready = 1'b0; sram_rdata = '0;
    if_pend = 1'b0; mem_pend = 1'b0; m_last = OWN_IF;
    @(negedge soc_clk);
    @(negedge soc_clk);
    MEM_reset = 1'b0;
  endtask

  // Serve one grant. Called at a negedge while the DUT is idle.
  task automatic run_round(input bit new_if, input bit new_mem, input int dly,
                           input int stall, output owner_t got);
    owner_t      exp_own;
    logic [31:0] e_addr, e_wdata, e_rdata, rd_val;
    logic [3:0]  e_be;
    logic        e_we, e_err, exp_ack_own, exp_ack_oth;
    int          e_cycles, acc;
    bit          seen;
    got = OWN_IF;
    rd_val = p_rdata;
    if (new_if && !if_pend) begin
      if_pend = 1'b1; m_if_addr = p_if_addr;
      if_req = 1'b1; if_addr = p_if_addr;
    end
    if (new_mem && !mem_pend) begin
      mem_pend = 1'b1; m_mem_addr = p_mem_addr; m_mem_be = p_mem_be;
      m_mem_we = p_mem_we; m_mem_wdata = p_mem_wdata;
      mem_req = 1'b1; mem_addr = p_mem_addr; mem_be = p_mem_be;
      mem_we = p_mem_we; mem_wdata = p_mem_wdata;
    end
    if (!if_pend && !mem_pend) return;

`ifdef MEM_ARB_RR_EN
    if (if_pend && mem_pend) exp_own = (m_last == OWN_IF) ? OWN_MEM : OWN_IF;
`else
    if (if_pend && mem_pend) exp_own = OWN_MEM;
`endif
    else exp_own = mem_pend ? OWN_MEM : OWN_IF;
    m_last = exp_own;

    if (exp_own == OWN_MEM) begin
      e_addr = m_mem_addr; e_be = m_mem_be; e_we = m_mem_we; e_wdata = m_mem_wdata;
    end else begin
      e_addr = m_if_addr; e_be = 4'hF; e_we = 1'b0; e_wdata = '0;
    end
    e_err    = (dly >= TMO);
    e_cycles = e_err ? TMO : dly + 1;
    e_rdata  = (e_err || e_we) ? 32'd0 : rd_val;

    MEM_stall = (stall > 0);
    for (int s = 0; s < stall; s++) begin
      sram_ready = 1'($urandom);
      @(negedge soc_clk);
      n_tests++;
      if (sram_req !== 1'b0)
        $display("FAIL stall_gate: sram_req=%b required 0 (stall cycle %0d)", sram_req, s);
      if (sram_req !== 1'b0) n_fail++;
    end
    MEM_stall = 1'b0;
    sram_ready = 1'($urandom);

    acc = 0;
    seen = 1'b0;
    for (int b = 0; b < TMO + 10 && !seen; b++) begin
      @(negedge soc_clk);
      if (b == 0) begin
        n_tests++;
        if (sram_req !== 1'b1) begin
          n_fail++;
          $display("FAIL latency: sram_req=%b required 1 one cycle after request", sram_req);
        end
      end
      if (if_ack === 1'b1 || mem_ack === 1'b1) begin
        seen = 1'b1;
        got = (mem_ack === 1'b1) ? OWN_MEM : OWN_IF;
        exp_ack_own = (exp_own == OWN_IF) ? if_ack : mem_ack;
        exp_ack_oth = (exp_own == OWN_IF) ? mem_ack : if_ack;
        n_tests++;
        if (exp_ack_own !== 1'b1 || exp_ack_oth !== 1'b0) begin
          n_fail++;
          $display("FAIL ack_owner: if_ack=%b mem_ack=%b required owner %s", if_ack, mem_ack, exp_own.name());
        end
        n_tests++;
        if (rdata !== e_rdata) begin
          n_fail++;
          $display("FAIL rdata: got %h required %h", rdata, e_rdata);
        end
        n_tests++;
        if (err !== e_err) begin
          n_fail++;
          $display("FAIL err: got %b required %b", err, e_err);
        end
        n_tests++;
        if (acc != e_cycles) begin
          n_fail++;
          $display("FAIL access_len: sram_req cycles %0d required %0d", acc, e_cycles);
        end
        if (exp_own == OWN_IF) begin if_req = 1'b0; if_pend = 1'b0; end
        else begin mem_req = 1'b0; mem_pend = 1'b0; end
        sram_ready = 1'($urandom);
      end else if (sram_req === 1'b1) begin
        n_tests++;
        if (sram_addr !== e_addr || sram_be !== e_be || sram_we !== e_we ||
            (e_we && sram_wdata !== e_wdata)) begin
          n_fail++;
          $display("FAIL sram_cmd: addr=%h be=%h we=%b wdata=%h required addr=%h be=%h we=%b wdata=%h",
                   sram_addr, sram_be, sram_we, sram_wdata, e_addr, e_be, e_we, e_wdata);
        end
        if (acc == dly) begin
          sram_ready = 1'b1; sram_rdata = rd_val;
        end else begin
          sram_ready = 1'b0; sram_rdata = $urandom;
        end
        acc++;
      end else begin
        sram_ready = 1'($urandom);
      end
    end

    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: no ack within %0d cycles", TMO + 10);
      do_reset();
      return;
    end
    @(negedge soc_clk);
    sram_ready = 1'b0;
    n_tests++;
    if (if_ack !== 1'b0 || mem_ack !== 1'b0 || sram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_pulse: if_ack=%b mem_ack=%b sram_req=%b required 0 0 0 after ack",
               if_ack, mem_ack, sram_req);
    end
  endtask

  task automatic test_reset();
    MEM_reset = 1'b1;
    do_reset();
    n_tests++;
    if (sram_req !== 1'b0 || if_ack !== 1'b0 || mem_ack !== 1'b0 || err !== 1'b0 ||
        rdata !== 32'd0 || sram_addr !== 32'd0 || sram_be !== 4'd0 ||
        sram_wdata !== 32'd0 || sram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: req=%b ifack=%b memack=%b err=%b rdata=%h addr=%h be=%h wd=%h we=%b required all 0",
               sram_req, if_ack, mem_ack, err, rdata, sram_addr, sram_be, sram_wdata, sram_we);
    end
  endtask

  task automatic test_fetch();
    owner_t got;
    do_reset();
    p_if_addr = 32'h100; p_rdata = 32'hDEADBEEF;
    run_round(1'b1, 1'b0, 0, 0, got);
    n_tests++;
    if (got !== OWN_IF) begin
      n_fail++;
      $display("FAIL fetch_owner: got %s required OWN_IF", got.name());
    end
  endtask

  task automatic test_back_to_back();
    owner_t g1, g2, g3;
    do_reset();
    p_if_addr = 32'h40; p_mem_addr = 32'h80; p_mem_be = 4'hF; p_mem_we = 1'b0;
    p_mem_wdata = '0; p_rdata = 32'hA5A5_0001;
    run_round(1'b1, 1'b1, 0, 0, g1);
    p_mem_addr = 32'h84; p_rdata = 32'hA5A5_0002;
    run_round(1'b0, 1'b1, 1, 0, g2);
    run_round(1'b0, 1'b0, 0, 0, g3);
    n_tests++;
    if (g1 !== OWN_MEM) begin
      n_fail++;
      $display("FAIL tie_first: got %s required OWN_MEM", g1.name());
    end
    n_tests++;
`ifdef MEM_ARB_RR_EN
    if (g2 !== OWN_IF) begin
      n_fail++;
      $display("FAIL tie_second: got %s required OWN_IF", g2.name());
    end
`else
    if (g2 !== OWN_MEM) begin
      n_fail++;
      $display("FAIL tie_second: got %s required OWN_MEM", g2.name());
    end
`endif
  endtask

  task automatic test_write();
    owner_t got;
    do_reset();
    p_mem_addr = 32'h2000; p_mem_be = 4'b0011; p_mem_we = 1'b1;
    p_mem_wdata = 32'h1234; p_rdata = 32'hFFFF_FFFF;
    run_round(1'b0, 1'b1, 2, 0, got);
  endtask

  task automatic test_timeout();
    owner_t got;
    do_reset();
    p_mem_addr = 32'h3000; p_mem_be = 4'hF; p_mem_we = 1'b0; p_rdata = 32'h1111_2222;
    run_round(1'b0, 1'b1, TMO + 3, 0, got);
    p_if_addr = 32'h3004;
    run_round(1'b1, 1'b0, TMO - 1, 0, got);
  endtask

  task automatic test_stall();
    owner_t got;
    do_reset();
    p_if_addr = 32'h500; p_rdata = 32'h0BAD_CAFE;
    run_round(1'b1, 1'b0, 1, 4, got);
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    if_req = 1'b1; if_addr = 32'h200;
    @(negedge soc_clk);
    n_tests++;
    if (sram_req !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_start: sram_req=%b required 1", sram_req);
    end
    @(negedge soc_clk);
    #2 MEM_reset = 1'b1;
    #1;
    n_tests++;
    if (sram_req !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: sram_req=%b required 0 right after reset", sram_req);
    end
    if_req = 1'b0;
    @(negedge soc_clk);
    MEM_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge soc_clk);
      n_tests++;
      if (if_ack !== 1'b0 || mem_ack !== 1'b0 || sram_req !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_noack: if_ack=%b mem_ack=%b sram_req=%b required 0 0 0",
                 if_ack, mem_ack, sram_req);
      end
    end
  endtask

  task automatic test_random();
    owner_t got;
    bit ni, nm;
    do_reset();
    for (int r = 0; r < 80; r++) begin
      ni = 1'($urandom); nm = 1'($urandom);
      if (!if_pend && !mem_pend && !ni && !nm) nm = 1'b1;
      p_if_addr = $urandom; p_mem_addr = $urandom; p_mem_be = 4'($urandom);
      p_mem_we = 1'($urandom); p_mem_wdata = $urandom; p_rdata = $urandom;
      run_round(ni, nm, int'($urandom_range(0, TMO + 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, got);
    end
    while (if_pend || mem_pend) begin
      p_rdata = $urandom;
      run_round(1'b0, 1'b0, int'($urandom_range(0, 3)), 0, got);
    end
  endtask

  initial begin
    MEM_reset = 1'b1;
    test_reset();
    test_fetch();
    test_back_to_back();
    test_write();
    test_timeout();
    test_stall();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 8, is the number of ACCESS cycles without sram_ready before an access is aborted (range 2..255).
REQ-002 soc_clk  in  1  system clock; all state changes on rising edge.
REQ-003 MEM_reset  in  1  asynchronous, active-high reset.
REQ-004 MEM_stall  in  1  while high, no new grant is issued.
REQ-005 if_req  in  1  fetch request, held until if_ack.
REQ-006 if_addr  in  32  fetch word address; a fetch is always a read with byte enables 4'hF.
REQ-007 if_ack  out  1  one-cycle response pulse to the fetch requester.
REQ-008 mem_req  in  1  data request, held until mem_ack.
REQ-009 mem_addr  in  32  data address.
REQ-010 mem_be  in  4  byte enables (bits_to_access).
REQ-011 mem_we  in  1  data direction: 1 = write, 0 = read.
REQ-012 mem_wdata  in  32  write data.
REQ-013 mem_ack  out  1  one-cycle response pulse to the data requester.
REQ-014 rdata  out  32  read data, valid while either ack is high.
REQ-015 err  out  1  timeout flag, valid while either ack is high.
REQ-016 sram_req  out  1  SRAM access strobe.
REQ-017 sram_addr / sram_be / sram_we / sram_wdata  out  32/4/1/32  latched command to the SRAM.
REQ-018 sram_ready  in  1  SRAM completion, sampled in ACCESS only.
REQ-019 sram_rdata  in  32  SRAM read data, valid with sram_ready.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-021 IDLE: on an edge with (if_req|mem_req) and !MEM_stall, the block SHALL latch the winner's command into the sram_* registers, record the owner, clear the timeout counter and enter ACCESS.
REQ-022 ACCESS: sram_req SHALL be high; on an edge with sram_ready, the block SHALL capture rdata (0 for a write), set err=0 and enter RESP.
REQ-023 ACCESS: when the counter reaches TIMEOUT_CYCLES without sram_ready, the block SHALL enter RESP with err=1 and rdata=0.
REQ-024 RESP: the owner's ack SHALL be high for exactly one cycle, then the FSM returns to IDLE; the non-owner's ack stays 0.
REQ-025 Minimum latency: request sampled at edge N, sram_req high during cycle N+1, sram_ready at edge N+1 gives ack high during cycle N+2.
REQ-026 A request that is still high in the cycle after its ack SHALL be treated as a new request.
REQ-027 MEM_stall SHALL gate only IDLE->ACCESS; an access already in ACCESS or RESP completes normally.
REQ-028 sram_req SHALL be low outside ACCESS; the sram_* command SHALL stay stable throughout ACCESS.
REQ-029 For a fetch, sram_we SHALL be 0 and sram_be SHALL be 4'hF.
REQ-030 sram_ready in IDLE or RESP SHALL be ignored.
REQ-031 The timeout counter SHALL be 8 bits, saturating, and cleared on entry to ACCESS.

Reset
REQ-032 MEM_reset SHALL force IDLE immediately, including mid-ACCESS (the access is abandoned without an ack).
REQ-033 Reset values: sram_req, if_ack, mem_ack and err = 0; rdata, sram_addr, sram_be, sram_wdata and sram_we = 0; round-robin pointer = IF-last.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: on simultaneous requests, grant SHALL go to the requester not granted last; the pointer updates on each IDLE->ACCESS transition.
REQ-035 MEM_ARB_RR_EN undefined: on simultaneous requests, mem_req SHALL always win (fixed priority); no pointer register exists.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the owner enum (OWN_IF/OWN_MEM) and the TIMEOUT_CYCLES default constant.
REQ-037 Grant selection SHALL be the combinational sub-module mem_arb_picker (inputs: both reqs, last-owner; output: winner).

Verification
REQ-038 Fetch only: if_req, if_addr=0x100, sram_ready one cycle later with rdata 0xDEADBEEF -> if_ack for one cycle, rdata=0xDEADBEEF, err=0, mem_ack=0.
REQ-039 Simultaneous fetch and data requests, twice back-to-back -> with RR_EN: MEM then IF; without RR_EN: MEM then MEM.
REQ-040 Write: mem_we=1, mem_be=4'b0011, mem_wdata=0x1234 -> sram_we=1, sram_be=4'b0011, sram_wdata=0x1234 while sram_req is high; mem_ack follows.
REQ-041 No sram_ready, TIMEOUT_CYCLES=8 -> sram_req high 8 cycles, then ack with err=1 and rdata=0.
REQ-042 MEM_stall high with if_req pending -> no sram_req; stall released -> access starts next edge. MEM_reset asserted mid-ACCESS -> sram_req 0 immediately, no ack.
